// File: rtl/cpu_sequencer.sv
// Purpose: registered control sequencer stepping instructions through LOAD/MOVE/ALU/TERM phases.
// Latency: accept to next instr_ready is 3 cycles for MOVE, ALU_CYCLES+2 for ALU, and 3+ for LOAD.
// Backpressure: instr_ready only in START; LOAD stalls on mem_ack, TERM stalls on resume.
module cpu_sequencer #(
    parameter int OPC_W      = 3,
    parameter int ALU_CYCLES = 3,
    parameter int CNT_W      = 2,
    parameter int RET_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [OPC_W-1:0] opcode,
    output logic             instr_ready,
    input  logic             mem_ack,
    input  logic             resume,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] alu_step,
    output logic             alu_op,
    output logic             done,
    output logic             halted,
    output logic             illegal,
    output logic [RET_W-1:0] retired
);

    typedef enum logic [3:0] {
        ST_START = 4'b0000,
        ST_LOAD  = 4'b0001,
        ST_MOVE  = 4'b0010,
        ST_ALU   = 4'b0011,
        ST_TERM  = 4'b0110,
        ST_DONE  = 4'b1111
    } state_t;

    localparam logic [OPC_W-1:0] OP_LOAD = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_MOVE = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_XOR  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_TERM = OPC_W'(4);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(ALU_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   alu_step_q, alu_step_d;
    logic               alu_op_q, alu_op_d;
    logic               illegal_q, illegal_d;
    logic [RET_W-1:0]   retired_q, retired_d;
    logic               accept;

    assign accept = instr_valid && (state_q == ST_START);

    always_comb begin
        state_d    = state_q;
        alu_step_d = alu_step_q;
        alu_op_d   = alu_op_q;
        illegal_d  = illegal_q;
        retired_d  = retired_q;
        case (state_q)
            ST_START: begin
                if (accept) begin
                    alu_op_d = opcode[0];
                    if (opcode == OP_LOAD) begin
                        state_d = ST_LOAD;
                    end else if (opcode == OP_MOVE) begin
                        state_d = ST_MOVE;
                    end else if (opcode == OP_ADD || opcode == OP_XOR) begin
                        state_d    = ST_ALU;
                        alu_step_d = '0;
                    end else if (opcode == OP_TERM) begin
                        state_d = ST_TERM;
                    end else begin
                        state_d   = ST_TERM;
                        illegal_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (mem_ack) begin
                    state_d = ST_DONE;
                end
            end
            ST_MOVE: begin
                state_d = ST_DONE;
            end
            ST_ALU: begin
                if (alu_step_q == STEP_LAST) begin
                    state_d    = ST_DONE;
                    alu_step_d = '0;
                end else begin
                    alu_step_d = alu_step_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                retired_d = retired_q + RET_W'(1);
                state_d   = ST_START;
            end
            ST_TERM: begin
                if (resume) begin
                    state_d = ST_START;
                end
            end
            // Unreachable encodings fall back to a clean START.
            default: begin
                state_d    = ST_START;
                alu_step_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_START;
            alu_step_q <= '0;
            alu_op_q   <= 1'b0;
            illegal_q  <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            alu_step_q <= alu_step_d;
            alu_op_q   <= alu_op_d;
            illegal_q  <= illegal_d;
            retired_q  <= retired_d;
        end
    end

    assign instr_ready = (state_q == ST_START);
    assign state       = state_q;
    assign alu_step    = alu_step_q;
    assign alu_op      = alu_op_q;
    assign done        = (state_q == ST_DONE);
    assign halted      = (state_q == ST_TERM);
    assign illegal     = illegal_q;
    assign retired     = retired_q;

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Registered control sequencer for the basic CPU. It replaces the unclocked next-state decoder with a clocked FSM.
- Accepts one instruction per valid/ready handshake and steps through LOAD/MOVE/ALU/TERM execution phases.
- ALU phase length and opcode width are configurable. LOAD waits on a memory acknowledge.
- Adds an illegal-opcode trap, halt/resume, and a retired-instruction counter. Sits between the instruction register and the datapath control decode.

Parameters:
- OPC_W, 3, opcode width; must be >= 3; opcodes 5..2^OPC_W-1 are illegal.
- ALU_CYCLES, 3, number of cycles spent in the ALU state; must be >= 1.
- CNT_W, 2, width of alu_step; must satisfy 2^CNT_W >= ALU_CYCLES.
- RET_W, 8, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  opcode on `opcode` is valid.
- opcode  in  OPC_W  0=LOAD 1=MOVE 2=ADD 3=XOR 4=TERM, others illegal.
- instr_ready  out  1  sequencer accepts an instruction this cycle.
- mem_ack  in  1  memory completion for LOAD.
- resume  in  1  leave TERM.
- state  out  4  current state: START=0000 LOAD=0001 MOVE=0010 ALU=0011 TERM=0110 DONE=1111.
- alu_step  out  CNT_W  cycle index within ALU state.
- alu_op  out  1  latched opcode bit0 (0=ADD, 1=XOR); valid while in ALU.
- done  out  1  high for the single DONE cycle.
- halted  out  1  high while in TERM.
- illegal  out  1  sticky: an illegal opcode was accepted.
- retired  out  RET_W  count of completed LOAD/MOVE/ADD/XOR instructions.

Behaviour:
- Reset: state=START, alu_step=0, alu_op=0, illegal=0, retired=0. All outputs are registered or decoded from registered state. Reset asserted mid-instruction aborts the instruction; no retire occurs.
- instr_ready = (state==START). Decoded from state, so it is 0 in every other state, including TERM.
- Accept = instr_valid && instr_ready. On accept, opcode bit0 latches into alu_op. Next state:
  - LOAD -> LOAD; MOVE -> MOVE.
  - ADD or XOR -> ALU, with alu_step=0.
  - TERM -> TERM.
  - Illegal -> TERM, with illegal<=1.
- START without accept stays in START.
- LOAD: stays until mem_ack=1, then DONE. mem_ack in any other state is ignored. mem_ack in the same cycle LOAD is entered does not count; it is sampled only while state==LOAD.
- MOVE: exactly one cycle, then DONE.
- ALU: occupies ALU_CYCLES consecutive cycles. alu_step increments 0..ALU_CYCLES-1. On the cycle with alu_step==ALU_CYCLES-1 the next state is DONE and alu_step returns to 0. With ALU_CYCLES=1, ALU lasts one cycle with alu_step=0.
- DONE: one cycle with done=1. retired increments by 1 with modulo 2^RET_W wrap. Next state is START.
- Minimum latencies, accept to next instr_ready:
  - MOVE = 3 cycles.
  - ALU = ALU_CYCLES+2 cycles.
  - LOAD = 3 cycles if mem_ack is already high on the first LOAD cycle.
- TERM: halted=1. Stays in TERM until resume=1, then goes to START. resume outside TERM is ignored. illegal is not cleared by resume; only reset clears it.
- TERM entry does not pass through DONE, so retired is not incremented.
- An undefined state encoding (unreachable) recovers to START on the next clock.

Test Plan:
- Reset, then MOVE (opcode=1) with instr_valid held -> state sequence START, MOVE, DONE, START; done high one cycle; retired=1.
- ALU_CYCLES=3, opcode=3 -> ALU for 3 cycles with alu_step 0,1,2 and alu_op=1; then DONE; retired increments.
- LOAD (opcode=0) with mem_ack low for 5 cycles, then high -> LOAD held 6 cycles total, then DONE. A mem_ack pulse sent while in MOVE has no effect.
- Illegal opcode 7 -> TERM with halted=1 and illegal=1; retired unchanged; resume=1 -> START; illegal stays 1 until reset.
- Preload retired to 255 (RET_W=8) with 255 instructions, then one more MOVE -> retired wraps to 0.
- Assert reset during ALU step 1 -> next cycle START, alu_step=0, retired unchanged; re-run ALU_CYCLES=1 build -> ALU lasts exactly one cycle.
